dds_multimode_nco: RTL and testbench
====================================

DDS_MULTIMODE_NCO -- requirements
Module: dds_multimode_nco

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, phase accumulator width; legal range 12..32.
REQ-002 SHALL have parameter OUT_W, default 12, signed output sample width; legal range 8..16, OUT_W <= PHASE_W.
REQ-003 SHALL have parameter AMP_W, default 12, unsigned amplitude width; legal range 4..16.
REQ-004 clk_in  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n_in  input  1  reset; synchronous, active-low.
REQ-006 enable_in  input  1  run; low clears the accumulator.
REQ-007 sync_in  input  1  phase restart strobe.
REQ-008 load_in  input  1  capture strobe for the configuration inputs.
REQ-009 wavesel_in  input  2  mode: 00 sine/off, 01 square, 10 sawtooth, 11 triangle.
REQ-010 ftw_in  input  PHASE_W  frequency tuning word.
REQ-011 poff_in  input  PHASE_W  phase offset.
REQ-012 duty_in  input  OUT_W  square high-threshold.
REQ-013 amp_in  input  AMP_W  amplitude scale.
REQ-014 wave_out  output  OUT_W  signed sample.
REQ-015 valid_out  output  1  wave_out is a live sample.
REQ-016 wrap_out  output  1  one-cycle pulse on accumulator carry.
REQ-017 busy_out  output  1  a captured configuration is pending.

Function
REQ-018 Accumulator acc SHALL add the active ftw each cycle while enable_in=1, modulo 2^PHASE_W; enable_in=0 SHALL clear acc to 0.
REQ-019 sync_in=1 SHALL clear acc to 0 and take priority over increment; no wrap_out is generated by sync_in.
REQ-020 wrap_out SHALL be registered, high for exactly the cycle after the cycle whose addition produced a carry.
REQ-021 load_in=1 SHALL copy wavesel_in, ftw_in, poff_in, duty_in and amp_in into a pending set and set busy_out on the next cycle; a second load_in while pending SHALL overwrite the pending set.
REQ-022 The pending set SHALL transfer to the active set, and busy_out SHALL clear, on the edge where a carry occurs, sync_in=1, or enable_in=0; active values SHALL never change otherwise.
REQ-023 When load_in and a transfer event coincide, the previously pending set SHALL be applied and the new capture SHALL become pending (busy_out stays 1).
REQ-024 Phase p = (acc + active poff) mod 2^PHASE_W; u = p[PHASE_W-1 -: OUT_W].
REQ-025 Sawtooth SHALL be u with MSB inverted (u - 2^(OUT_W-1)).
REQ-026 Square SHALL be +(2^(OUT_W-1)-1) when u < duty, else -2^(OUT_W-1); duty=0 yields constant negative.
REQ-027 Triangle: f = u[OUT_W-2:0] when u MSB=0, else its bitwise inverse; sample = {f,0} with MSB inverted.
REQ-028 Scaled sample SHALL be floor((raw x amp) / 2^AMP_W), full signed product, arithmetic shift, no saturation needed.
REQ-029 Pipeline SHALL be two register stages: wave_out at edge n+2 reflects acc and active configuration at edge n.
REQ-030 valid_out SHALL equal enable_in delayed two cycles; while valid_out=0, wave_out SHALL be 0.

Reset
REQ-031 rst_n_in=0 SHALL clear acc, both pipeline stages, active and pending sets, wave_out, valid_out, wrap_out, busy_out to 0; reset mid-operation discards any pending load.
REQ-032 The first enabled sample after reset SHALL appear two cycles after enable_in rises.

Configuration
REQ-033 Macro NCO_PARABOLIC_SINE_EN defined: mode 00 SHALL output y = 4x(1-|x|) with x = u as signed Q(OUT_W-1), saturated to +(2^(OUT_W-1)-1), same two-cycle latency.
REQ-034 Macro NCO_PARABOLIC_SINE_EN undefined: mode 00 SHALL output raw 0 (valid_out unaffected) and no sine multiplier SHALL be synthesised.

Verification (defaults PHASE_W=24, OUT_W=12, AMP_W=12)
REQ-035 Reset: rst_n_in=0 for 3 cycles during running sawtooth -> wave_out=0, valid_out=0, wrap_out=0, busy_out=0 on the following edge.
REQ-036 Sawtooth: load ftw=0x100000, amp=0x800, poff=0, enable -> wave_out -1024, -896, -768 ... 896, repeating every 16 cycles, wrap_out once per 16 cycles.
REQ-037 Triangle: same ftw, amp=0x800, mode 11 -> -1024, -768, ... up to 1023 at u=2048 region, then descending; period 16 cycles.
REQ-038 Deferred load: running ftw=0x100000, load ftw=0x200000 at cycle 5 of a period -> busy_out=1 until wrap, step doubles only after carry, busy_out=0 thereafter.
REQ-039 Square duty: duty=0x400, ftw=0x100000, amp=0xFFF -> 4 samples of +2046, 12 samples of -2048 per period.
REQ-040 sync_in pulse mid-period with pending load -> acc=0 next edge, pending set applied, busy_out=0, no wrap_out pulse.

Source files
------------

// File: rtl/dds_multimode_nco_if.sv
// Configuration/sample bundle for dds_multimode_nco.
// master drives the controls and config words; slave (the NCO) drives the sample outputs.
interface dds_multimode_nco_if #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned OUT_W   = 12,
  parameter int unsigned AMP_W   = 12
);
  logic                     enable_in;
  logic                     sync_in;
  logic                     load_in;
  logic [1:0]               wavesel_in;
  logic [PHASE_W-1:0]       ftw_in;
  logic [PHASE_W-1:0]       poff_in;
  logic [OUT_W-1:0]         duty_in;
  logic [AMP_W-1:0]         amp_in;
  logic signed [OUT_W-1:0]  wave_out;
  logic                     valid_out;
  logic                     wrap_out;
  logic                     busy_out;

  modport master (
    output enable_in, sync_in, load_in, wavesel_in, ftw_in, poff_in, duty_in, amp_in,
    input  wave_out, valid_out, wrap_out, busy_out
  );

  modport slave (
    input  enable_in, sync_in, load_in, wavesel_in, ftw_in, poff_in, duty_in, amp_in,
    output wave_out, valid_out, wrap_out, busy_out
  );
endinterface

// File: rtl/dds_multimode_nco.sv
// Multi-mode NCO: phase accumulator, deferred config transfer, two-stage wave/amp pipeline.
// Optional parabolic sine in mode 00 when NCO_PARABOLIC_SINE_EN is defined.
module dds_multimode_nco #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned OUT_W   = 12,
  parameter int unsigned AMP_W   = 12
) (
  input logic                clk_in,
  input logic                rst_n_in,
  dds_multimode_nco_if.slave bus
);

  typedef struct packed {
    logic [1:0]         wsel;
    logic [PHASE_W-1:0] ftw;
    logic [PHASE_W-1:0] poff;
    logic [OUT_W-1:0]   duty;
    logic [AMP_W-1:0]   amp;
  } cfg_t;

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  localparam logic [OUT_W-1:0] POS_FS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_FS = {1'b1, {(OUT_W-1){1'b0}}};

  state_t                        state_q, state_d;
  cfg_t                          cap, act_q, pend_q;
  logic [PHASE_W-1:0]            acc_q, phase;
  logic [PHASE_W:0]              sum;
  logic                          carry_evt, xfer, wrap_q;
  logic [OUT_W-1:0]              u, raw, raw_q, wave_q;
  logic [OUT_W-2:0]              tri_f;
  logic [AMP_W-1:0]              amp_q;
  logic                          v1_q, valid_q;
  logic signed [OUT_W+AMP_W-1:0] raw_ext, amp_ext, prod;
  logic                          unused_bits;

  assign cap = '{wsel: bus.wavesel_in, ftw: bus.ftw_in, poff: bus.poff_in,
                 duty: bus.duty_in, amp: bus.amp_in};

  assign sum       = {1'b0, acc_q} + {1'b0, act_q.ftw};
  assign carry_evt = bus.enable_in && !bus.sync_in && sum[PHASE_W];
  // Pending set moves to active on carry, sync or disable; a coincident load re-arms pending.
  assign xfer      = (state_q == ST_PENDING) && (carry_evt || bus.sync_in || !bus.enable_in);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.load_in)  state_d = ST_PENDING;
    else if (xfer)    state_d = ST_IDLE;
  end

  always_comb begin
    bus.busy_out = (state_q == ST_PENDING);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      acc_q  <= '0;
      act_q  <= '0;
      pend_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= (!bus.enable_in || bus.sync_in) ? '0 : sum[PHASE_W-1:0];
      wrap_q <= carry_evt;
      if (xfer)        act_q  <= pend_q;
      if (bus.load_in) pend_q <= cap;
    end
  end

  assign phase = acc_q + act_q.poff;
  assign u     = phase[PHASE_W-1 -: OUT_W];

`ifdef NCO_PARABOLIC_SINE_EN
  localparam int unsigned SW = 2*OUT_W + 1;
  logic [OUT_W-1:0]     mag, comp, sine;
  logic signed [SW-1:0] x_ext, c_ext, sprod, sshift;

  // y = 4x(1-|x|) in Q(OUT_W-1): x*(1-|x|) scaled by 4/2^(OUT_W-1) is a shift by OUT_W-3.
  always_comb begin
    mag    = u[OUT_W-1] ? ('0 - u) : u;
    comp   = NEG_FS - mag;
    x_ext  = {{(OUT_W+1){u[OUT_W-1]}}, u};
    c_ext  = {{(OUT_W+1){1'b0}}, comp};
    sprod  = x_ext * c_ext;
    sshift = sprod >>> (OUT_W-3);
    if (!sshift[SW-1] && (sshift[SW-2:OUT_W-1] != '0)) sine = POS_FS;
    else                                               sine = sshift[OUT_W-1:0];
  end
`endif

  always_comb begin
    tri_f = u[OUT_W-1] ? ~u[OUT_W-2:0] : u[OUT_W-2:0];
    raw   = '0;
    case (act_q.wsel)
      2'b01:   raw = (u < act_q.duty) ? POS_FS : NEG_FS;
      2'b10:   raw = {~u[OUT_W-1], u[OUT_W-2:0]};
      2'b11:   raw = {~tri_f[OUT_W-2], tri_f[OUT_W-3:0], 1'b0};
`ifdef NCO_PARABOLIC_SINE_EN
      default: raw = sine;
`else
      default: raw = '0;
`endif
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      raw_q <= '0;
      amp_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      raw_q <= raw;
      amp_q <= act_q.amp;
      v1_q  <= bus.enable_in;
    end
  end

  assign raw_ext = {{AMP_W{raw_q[OUT_W-1]}}, raw_q};
  assign amp_ext = {{OUT_W{1'b0}}, amp_q};
  assign prod    = raw_ext * amp_ext;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wave_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wave_q  <= v1_q ? prod[AMP_W +: OUT_W] : '0;
      valid_q <= v1_q;
    end
  end

  assign bus.wave_out  = wave_q;
  assign bus.valid_out = valid_q;
  assign bus.wrap_out  = wrap_q;
  assign unused_bits   = ^{phase, prod};

endmodule

// File: tb/tb_dds_multimode_nco.sv
// Scoreboard bench for dds_multimode_nco: behavioural model feeds expectation queues,
// an independent monitor compares DUT outputs on the falling edge.
module tb_dds_multimode_nco;
  localparam int PW = 24;
  localparam int OW = 12;
  localparam int AW = 12;
  localparam longint MOD   = longint'(1) << PW;
  localparam longint HALF  = longint'(1) << (OW-1);
  localparam longint FULL  = longint'(1) << OW;
  localparam longint SCALE = longint'(1) << AW;

  typedef struct { int wsel; longint ftw; longint poff; longint duty; longint amp; } cfg_t;
  typedef struct { bit wrap; bit busy; bit valid; } stat_t;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  dds_multimode_nco_if #(.PHASE_W(PW), .OUT_W(OW), .AMP_W(AW)) bus ();
  dds_multimode_nco #(.PHASE_W(PW), .OUT_W(OW), .AMP_W(AW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int    sample_q[$];
  stat_t stat_q[$];

  cfg_t   m_act, m_pend;
  bit     m_pending, m_prev_en;
  longint m_acc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  function automatic longint floordiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int ref_sample(input longint acc, input cfg_t c);
    longint p, u, raw;
`ifdef NCO_PARABOLIC_SINE_EN
    longint x, ax;
`endif
    p = (acc + c.poff) % MOD;
    u = p / (MOD / FULL);
    case (c.wsel)
      1: raw = (u < c.duty) ? HALF - 1 : -HALF;
      2: raw = u - HALF;
      3: raw = (u < HALF) ? 2*u - HALF : 2*(FULL - 1 - u) - HALF;
      default: begin
`ifdef NCO_PARABOLIC_SINE_EN
        x   = (u >= HALF) ? u - FULL : u;
        ax  = (x < 0) ? -x : x;
        raw = floordiv(4 * x * (HALF - ax), HALF);
        if (raw > HALF - 1) raw = HALF - 1;
`else
        raw = 0;
`endif
      end
    endcase
    return int'(floordiv(raw * c.amp, SCALE));
  endfunction

  // One clock: advance the model on the inputs currently driven, then queue its predictions.
  task automatic tick();
    stat_t  e;
    bit     push, flush, en, sy, ld, carry, trans;
    int     s;
    cfg_t   cin;
    push = 0; flush = 0; s = 0;
    e = '{wrap: 0, busy: 0, valid: 0};
    if (!rst_n_in) begin
      m_acc = 0; m_act = '{default: 0}; m_pend = '{default: 0};
      m_pending = 0; m_prev_en = 0; flush = 1;
    end else begin
      en = bus.enable_in; sy = bus.sync_in; ld = bus.load_in;
      cin = '{wsel: int'(bus.wavesel_in), ftw: longint'(bus.ftw_in), poff: longint'(bus.poff_in),
              duty: longint'(bus.duty_in), amp: longint'(bus.amp_in)};
      carry = en && !sy && (m_acc + m_act.ftw >= MOD);
      trans = m_pending && (!en || sy || carry);
      if (en) begin push = 1; s = ref_sample(m_acc, m_act); end
      e.valid   = m_prev_en;
      m_prev_en = en;
      m_acc = (en && !sy) ? (m_acc + m_act.ftw) % MOD : 0;
      if (trans) m_act = m_pend;
      if (ld) begin m_pend = cin; m_pending = 1; end
      else if (trans) m_pending = 0;
      e.wrap = carry;
      e.busy = m_pending;
    end
    @(posedge clk_in);
    if (flush) sample_q.delete();
    if (push) sample_q.push_back(s);
    stat_q.push_back(e);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_load(input int wsel, input longint ftw, input longint poff,
                          input longint duty, input longint amp);
    bus.load_in    = 1'b1;
    bus.wavesel_in = 2'(wsel);
    bus.ftw_in     = PW'(ftw);
    bus.poff_in    = PW'(poff);
    bus.duty_in    = OW'(duty);
    bus.amp_in     = AW'(amp);
  endtask

  initial begin : monitor
    stat_t e;
    int    s;
    forever begin
      @(negedge clk_in);
      if (stat_q.size() > 0) begin
        e = stat_q.pop_front();
        chk("valid_out", longint'(bus.valid_out), longint'(e.valid));
        chk("wrap_out",  longint'(bus.wrap_out),  longint'(e.wrap));
        chk("busy_out",  longint'(bus.busy_out),  longint'(e.busy));
        if (bus.valid_out) begin
          if (sample_q.size() == 0) chk("sample_available", 0, 1);
          else begin
            s = sample_q.pop_front();
            chk("wave_out", longint'(bus.wave_out), longint'(s));
          end
        end else begin
          chk("wave_out_idle_zero", longint'(bus.wave_out), 0);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n_in = 1'b0;
    bus.enable_in = 1'b0; bus.sync_in = 1'b0; bus.load_in = 1'b0;
    bus.wavesel_in = '0; bus.ftw_in = '0; bus.poff_in = '0; bus.duty_in = '0; bus.amp_in = '0;
    ticks(3);
    rst_n_in = 1'b1;

    // Sawtooth, 16-cycle period
    set_load(2, 'h100000, 0, 0, 'h800); tick();
    bus.load_in = 1'b0; tick();
    bus.enable_in = 1'b1; ticks(40);

    // Reset mid-run, with a load offered during reset that must be discarded
    rst_n_in = 1'b0; set_load(3, 'h300000, 0, 0, 'hFFF); tick();
    bus.load_in = 1'b0; ticks(2);
    rst_n_in = 1'b1; bus.enable_in = 1'b0; tick();

    // Triangle
    set_load(3, 'h100000, 0, 0, 'h800); tick();
    bus.load_in = 1'b0; tick();
    bus.enable_in = 1'b1; ticks(36);

    // Deferred ftw change mid-period
    ticks(5);
    set_load(3, 'h200000, 0, 0, 'h800); tick();
    bus.load_in = 1'b0; ticks(30);

    // Back-to-back loads so that some coincide with a carry-driven transfer
    for (int i = 0; i < 10; i++) begin
      set_load(2 + (i % 2), (i % 2) ? 'h200000 : 'h100000, i * 'h10000, 0, 'h400 + i * 'h100);
      tick();
    end
    bus.load_in = 1'b0; ticks(24);

    // Square, duty 0x400, full amplitude; then duty 0
    set_load(1, 'h100000, 0, 'h400, 'hFFF); tick();
    bus.load_in = 1'b0; ticks(40);
    set_load(1, 'h100000, 0, 0, 'hFFF); tick();
    bus.load_in = 1'b0; ticks(36);

    // Sync pulse mid-period with a pending load
    ticks(5);
    set_load(2, 'h180000, 'h400000, 0, 'hFFF); tick();
    bus.load_in = 1'b0; ticks(3);
    bus.sync_in = 1'b1; tick();
    bus.sync_in = 1'b0; ticks(20);

    // Mode 00 with nonzero amplitude
    set_load(0, 'h0C0000, 'h123456, 'h200, 'hABC); tick();
    bus.load_in = 1'b0; ticks(30);

    // Randomised traffic
    for (int i = 0; i < 700; i++) begin
      rst_n_in      = ($urandom_range(0, 249) != 0);
      bus.enable_in = ($urandom_range(0, 31) != 0);
      bus.sync_in   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0)
        set_load(int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) != 0) ? (longint'('h80000) << $urandom_range(0, 3))
                                             : longint'($urandom) % MOD,
                 longint'($urandom) % MOD,
                 longint'($urandom_range(0, 4095)),
                 longint'($urandom_range(0, 4095)));
      else
        bus.load_in = 1'b0;
      tick();
    end

    // Drain
    rst_n_in = 1'b1; bus.enable_in = 1'b0; bus.sync_in = 1'b0; bus.load_in = 1'b0;
    ticks(4);
    #6;
    chk("sample_queue_drained", longint'(sample_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
